// File: rtl/dense_layer_controller_if.sv
// Bus bundle between the dense-layer sequencer and its datapath: the
// control handshake, the input-buffer/ROM addressing, the MAC control
// and result, and the write port into the layer output buffer.
interface dense_layer_controller_if;
  logic               start;
  logic               busy;
  logic               done;
  logic               error;
  logic [9:0]         in_addr;
  logic [3:0]         rom_bank;
  logic               mac_frame_start;
  logic               mac_ena;
  logic               mac_frame_end;
  logic               mac_valid;
  logic signed [15:0] mac_sum;
  logic               out_we;
  logic [3:0]         out_addr;
  logic signed [15:0] out_data;

  // Controller side.
  modport master (
    input  start, mac_valid, mac_sum,
    output busy, done, error, in_addr, rom_bank,
           mac_frame_start, mac_ena, mac_frame_end,
           out_we, out_addr, out_data
  );

  // Datapath / host side.
  modport slave (
    output start, mac_valid, mac_sum,
    input  busy, done, error, in_addr, rom_bank,
           mac_frame_start, mac_ena, mac_frame_end,
           out_we, out_addr, out_data
  );
endinterface

// File: rtl/dense_layer_controller.sv
// Sequencer for one fully connected layer. For each neuron it clears the
// MAC, streams N_IN input-vector addresses with mac_ena, waits (bounded)
// for the MAC result, applies optional ReLU and writes one output word.
// A missing MAC result aborts the pass with a sticky error flag.
module dense_layer_controller #(
  parameter int N_IN       = 980,
  parameter int N_OUT      = 10,
  parameter int WAIT_LIMIT = 15,
  parameter int RELU_EN    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  dense_layer_controller_if.master   bus
);

  localparam int              CW        = $clog2(WAIT_LIMIT + 1);
  localparam logic [9:0]      LAST_ADDR = 10'(N_IN - 1);
  localparam logic [3:0]      LAST_IDX  = 4'(N_OUT - 1);
  localparam logic [CW-1:0]   LAST_WAIT = CW'(WAIT_LIMIT - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, WAIT, WRITE, NEXT} state_t;

  state_t          state_reg;
  logic [3:0]      idx_reg;
  logic [CW-1:0]   wait_cnt_reg;

  // The neuron index doubles as the weight ROM bank select.
  assign bus.rom_bank = idx_reg;
  assign bus.busy     = (state_reg != IDLE);

  // Layer sequencer: state, neuron index, wait counter and every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg           <= IDLE;
      idx_reg             <= '0;
      wait_cnt_reg        <= '0;
      bus.done            <= 1'b0;
      bus.error           <= 1'b0;
      bus.in_addr         <= '0;
      bus.mac_frame_start <= 1'b0;
      bus.mac_ena         <= 1'b0;
      bus.mac_frame_end   <= 1'b0;
      bus.out_we          <= 1'b0;
      bus.out_addr        <= '0;
      bus.out_data        <= '0;
    end else begin
      // Pulse-type outputs default low; the state that needs one raises it.
      bus.done            <= 1'b0;
      bus.mac_frame_start <= 1'b0;
      bus.mac_frame_end   <= 1'b0;
      bus.out_we          <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg           <= CLEAR;
            idx_reg             <= '0;
            bus.error           <= 1'b0;
            bus.mac_frame_start <= 1'b1;
            bus.in_addr         <= '0;
          end
        end
        CLEAR: begin
          state_reg         <= STREAM;
          bus.mac_ena       <= 1'b1;
          bus.in_addr       <= '0;
          bus.mac_frame_end <= (LAST_ADDR == 10'd0);
        end
        STREAM: begin
          if (bus.in_addr == LAST_ADDR) begin
            state_reg    <= WAIT;
            bus.mac_ena  <= 1'b0;
            bus.in_addr  <= '0;
            wait_cnt_reg <= '0;
          end else begin
            bus.in_addr       <= bus.in_addr + 10'd1;
            bus.mac_frame_end <= ((bus.in_addr + 10'd1) == LAST_ADDR);
          end
        end
        WAIT: begin
          // A result in the final allowed cycle still wins over the timeout.
          if (bus.mac_valid) begin
            state_reg    <= WRITE;
            bus.out_we   <= 1'b1;
            bus.out_addr <= idx_reg;
            bus.out_data <= ((RELU_EN != 0) && bus.mac_sum[15]) ? 16'sd0 : bus.mac_sum;
          end else if (wait_cnt_reg == LAST_WAIT) begin
            state_reg <= IDLE;
            bus.error <= 1'b1;
            bus.done  <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        WRITE: begin
          state_reg <= NEXT;
        end
        NEXT: begin
          if (idx_reg == LAST_IDX) begin
            state_reg <= IDLE;
            bus.done  <= 1'b1;
          end else begin
            idx_reg             <= idx_reg + 4'd1;
            state_reg           <= CLEAR;
            bus.mac_frame_start <= 1'b1;
            bus.in_addr         <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_controller.sv
// Scoreboard bench: the driver plans each pass (MAC delay and sum per
// neuron), a reference model derives the expected writes, duration and
// error, and a monitor compares them against what the controllers present.
// Two controllers share stimulus: one with ReLU, one without.
module tb_dense_layer_controller;

  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int WL    = 10;
  localparam int NEVER = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dense_layer_controller_if b0 ();
  dense_layer_controller_if b1 ();

  dense_layer_controller #(.N_IN(N_IN), .N_OUT(N_OUT), .WAIT_LIMIT(WL), .RELU_EN(1))
    u0 (.clk(clk), .rst(rst), .bus(b0));
  dense_layer_controller #(.N_IN(N_IN), .N_OUT(N_OUT), .WAIT_LIMIT(WL), .RELU_EN(0))
    u1 (.clk(clk), .rst(rst), .bus(b1));

  assign b1.start     = b0.start;
  assign b1.mac_valid = b0.mac_valid;
  assign b1.mac_sum   = b0.mac_sum;

  typedef struct { logic [3:0] addr; logic [15:0] data; } wr_t;
  typedef struct { int cyc; logic err; int frames; } done_t;

  wr_t   wr0_q[$];
  wr_t   wr1_q[$];
  done_t done_q[$];

  int                 p_delay [N_OUT];
  logic signed [15:0] p_sum   [N_OUT];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   epoch    = 0;
  logic exp_err_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle counter; the value read at a negedge is the current cycle number.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: walk the neurons, stop at the first one whose MAC
  // result would come later than the wait limit.
  task automatic plan_pass(output int len, output logic err, output int frames);
    len = 0; err = 1'b0; frames = 0;
    for (int n = 0; n < N_OUT; n++) begin
      frames++;
      len += 1 + N_IN;
      if (p_delay[n] > WL) begin
        len += WL;
        err = 1'b1;
        break;
      end
      len += p_delay[n] + 2;
      wr0_q.push_back('{4'(n), (p_sum[n] < 16'sd0) ? 16'h0000 : p_sum[n]});
      wr1_q.push_back('{4'(n), p_sum[n]});
    end
  endtask

  task automatic rand_plan(input int timeout_pct);
    for (int n = 0; n < N_OUT; n++) begin
      if (int'($urandom_range(99)) < timeout_pct)
        p_delay[n] = ($urandom_range(1) == 1) ? WL + 1 : NEVER;
      else
        p_delay[n] = int'($urandom_range(WL, 1));
      p_sum[n] = 16'($urandom);
    end
  endtask

  task automatic check_zero(input string name);
    chk(name, 32'({b0.busy, b0.done, b0.error, b0.in_addr, b0.rom_bank, b0.mac_frame_start,
                   b0.mac_ena, b0.mac_frame_end, b0.out_we, b0.out_addr}), 0);
    chk({name, "_data"}, 32'({b0.out_data, b1.out_data}), 0);
  endtask

  // One pass: start, optionally keep start high throughout, return on the cycle after done.
  task automatic run_pass(input bit hammer, input int gap);
    int len, frames, c0;
    logic err;
    repeat (gap) @(negedge clk);
    chk("error_sticky", 32'(b0.error), 32'(exp_err_prev));
    plan_pass(len, err, frames);
    c0 = cyc;
    done_q.push_back('{c0 + len + 1, err, frames});
    b0.start = 1'b1;
    @(negedge clk);
    chk("start_busy", 32'(b0.busy), 1);
    chk("start_error_clear", 32'(b0.error), 0);
    b0.start = hammer;
    while (cyc < c0 + len) @(negedge clk);
    @(negedge clk);
    b0.start = 1'b0;
    @(negedge clk);
    exp_err_prev = err;
  endtask

  // Reset on the third STREAM cycle of neuron 1, with a start in the same cycle.
  task automatic reset_mid_stream();
    int len, frames, c0, clr1;
    logic err;
    rand_plan(0);
    plan_pass(len, err, frames);
    while (wr0_q.size() > 1) void'(wr0_q.pop_back());
    while (wr1_q.size() > 1) void'(wr1_q.pop_back());
    c0 = cyc;
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    clr1 = c0 + 1 + N_IN + p_delay[0] + 3;
    while (cyc < clr1 + 3) @(negedge clk);
    chk("pre_reset_addr", 32'(b0.in_addr), 2);
    chk("pre_reset_bank", 32'(b0.rom_bank), 1);
    rst = 1'b1;
    b0.start = 1'b1;
    @(negedge clk);
    check_zero("mid_reset");
    rst = 1'b0;
    b0.start = 1'b0;
    chk("neuron0_written0", 32'(wr0_q.size()), 0);
    chk("neuron0_written1", 32'(wr1_q.size()), 0);
    wr0_q.delete(); wr1_q.delete(); done_q.delete();
    epoch++;
    exp_err_prev = 1'b0;
    @(negedge clk);
    chk("reset_idle", 32'(b0.busy), 0);
  endtask

  // MAC model: result arrives p_delay cycles after frame_end; stray valids
  // with junk sums are thrown in while the controller is streaming or writing.
  initial begin
    int cnt = 0;
    int my_epoch = 0;
    int d, idx;
    logic [15:0] pend = '0;
    logic v;
    logic [15:0] s;
    b0.mac_valid = 1'b0;
    b0.mac_sum   = '0;
    forever begin
      @(negedge clk);
      if (my_epoch != epoch) begin
        my_epoch = epoch;
        cnt = 0;
      end
      v = 1'b0;
      s = 16'($urandom);
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          v = 1'b1;
          s = pend;
        end
      end else if (((b0.mac_ena && !b0.mac_frame_end) || b0.out_we) && $urandom_range(3) == 0) begin
        v = 1'b1;
      end
      if (b0.mac_frame_end) begin
        idx = int'(b0.rom_bank);
        d = (idx < N_OUT) ? p_delay[idx] : 6;
        pend = (idx < N_OUT) ? p_sum[idx] : 16'h0;
        cnt = (d <= WL + 1) ? d : 0;
      end
      b0.mac_valid = v;
      b0.mac_sum   = s;
    end
  end

  // Monitor: compares bus activity against the scoreboard queues.
  initial begin
    int exp_addr = 0;
    int frames = 0;
    int fe_cnt = 0;
    int my_epoch = 0;
    wr_t w;
    done_t dn;
    forever begin
      @(negedge clk);
      if (my_epoch != epoch) begin
        my_epoch = epoch;
        exp_addr = 0; frames = 0; fe_cnt = 0;
      end
      if (b0.mac_frame_start) begin
        chk("clear_ena", 32'(b0.mac_ena), 0);
        chk("clear_addr", 32'(b0.in_addr), 0);
        chk("clear_bank", 32'(b0.rom_bank), frames);
        frames++;
        exp_addr = 0;
      end
      if (b0.mac_ena) begin
        chk("stream_addr", 32'(b0.in_addr), exp_addr);
        chk("stream_frame_end", 32'(b0.mac_frame_end), 32'(exp_addr == N_IN - 1));
        chk("stream_bank", 32'(b0.rom_bank), frames - 1);
        chk("stream_busy", 32'(b0.busy), 1);
        exp_addr++;
      end else begin
        chk("frame_end_idle", 32'(b0.mac_frame_end), 0);
      end
      if (b0.mac_frame_end) fe_cnt++;
      if (b0.out_we) begin
        chk("write_ena_count", exp_addr, N_IN);
        chk("write_expected0", 32'(wr0_q.size() > 0), 1);
        if (wr0_q.size() > 0) begin
          w = wr0_q.pop_front();
          chk("write_addr0", 32'(b0.out_addr), 32'(w.addr));
          chk("write_data0", {16'h0, b0.out_data}, {16'h0, w.data});
        end
      end
      if (b1.out_we) begin
        chk("write_expected1", 32'(wr1_q.size() > 0), 1);
        if (wr1_q.size() > 0) begin
          w = wr1_q.pop_front();
          chk("write_addr1", 32'(b1.out_addr), 32'(w.addr));
          chk("write_data1", {16'h0, b1.out_data}, {16'h0, w.data});
        end
      end
      if (b0.done) begin
        chk("done_busy", 32'(b0.busy), 0);
        chk("done_ena_count", exp_addr, N_IN);
        chk("done_expected", 32'(done_q.size() > 0), 1);
        if (done_q.size() > 0) begin
          dn = done_q.pop_front();
          chk("done_cycle", cyc, dn.cyc);
          chk("done_error", 32'(b0.error), 32'(dn.err));
          chk("frame_starts", frames, dn.frames);
          chk("frame_ends", fe_cnt, dn.frames);
        end
        frames = 0;
        fe_cnt = 0;
      end
    end
  end

  // Stimulus sequence.
  initial begin
    b0.start = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    b0.start = 1'b1;
    check_zero("reset_hold");
    @(negedge clk);
    rst = 1'b0;
    b0.start = 1'b0;
    check_zero("reset_start_ignored");
    @(negedge clk);
    chk("idle_after_reset", 32'(b0.busy), 0);

    // Reference case: sums +100 then -5, result 6 cycles after frame_end.
    p_delay[0] = 6; p_delay[1] = 6;
    p_sum[0] = 16'sd100; p_sum[1] = -16'sd5;
    run_pass(1'b0, 0);

    // start held high through a pass, then a start the cycle after done.
    rand_plan(0); run_pass(1'b1, 1);
    rand_plan(0); run_pass(1'b0, 0);

    // Result on the last allowed wait cycle, then one cycle too late.
    rand_plan(0); p_delay[0] = WL; p_delay[1] = WL + 1;
    run_pass(1'b0, 0);
    // MAC never answers on the first neuron.
    rand_plan(0); p_delay[0] = NEVER;
    run_pass(1'b0, 2);
    rand_plan(0); run_pass(1'b0, 0);

    reset_mid_stream();
    rand_plan(0); run_pass(1'b0, 1);

    for (int i = 0; i < 8; i++) begin
      rand_plan(25);
      run_pass(1'($urandom_range(1)), int'($urandom_range(3)));
    end

    repeat (WL + 5) @(negedge clk);
    chk("done_drained", 32'(done_q.size()), 0);
    chk("writes_drained0", 32'(wr0_q.size()), 0);
    chk("writes_drained1", 32'(wr1_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
